// File: rtl/ball_motion.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ball_motion : per-frame ball trajectory engine with make/miss detection,
//               hold-then-rerack sequencing and saturating score counters.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module ball_motion #(
   parameter int START_X     = 40,
   parameter int START_Y     = 400,
   parameter int RIM_X_MIN   = 600,
   parameter int RIM_X_MAX   = 630,
   parameter int RIM_Y       = 256,
   parameter int FLOOR_Y     = 470,
   parameter int X_MAX       = 639,
   parameter int GRAV_DIV    = 2,
   parameter int HOLD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       launch,
   input  logic [5:0] vx_init,
   input  logic [7:0] vy_init,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       in_flight,
   output logic       scored,
   output logic       missed,
   output logic [7:0] shots,
   output logic [7:0] makes
);

   localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [9:0]         C_START_X  = 10'(START_X);
   localparam logic [9:0]         C_START_Y  = 10'(START_Y);
   localparam logic [9:0]         C_RIM_Y10  = 10'(RIM_Y);
   localparam logic [9:0]         C_FLOOR10  = 10'(FLOOR_Y);
   localparam logic [9:0]         C_XMAX10   = 10'(X_MAX);
   localparam logic signed [11:0] C_RIM_Y12  = 12'(RIM_Y);
   localparam logic signed [11:0] C_RIM_XL   = 12'(RIM_X_MIN);
   localparam logic signed [11:0] C_RIM_XR   = 12'(RIM_X_MAX);
   localparam logic signed [11:0] C_FLOOR12  = 12'(FLOOR_Y);
   localparam logic signed [11:0] C_XMAX12   = 12'(X_MAX);
   localparam logic [3:0]         C_GRAV_END = 4'(GRAV_DIV - 1);
   localparam logic [HCW-1:0]     C_HOLD_END = HCW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t             state_q;
   logic [9:0]         x_q, y_q;
   logic [5:0]         vx_q;
   logic signed [7:0]  vy_q;
   logic [3:0]         grav_q;
   logic [HCW-1:0]     hold_q;
   logic               in_flight_q, scored_q, missed_q;
   logic [7:0]         shots_q, makes_q;

   logic signed [11:0] nx, ny;
   logic               make_hit, miss_hit;
   logic [9:0]         y_top_clamped;

   // Candidate position uses the pre-tick velocity in 12-bit signed math.
   assign nx = $signed({2'b00, x_q}) + $signed({6'b000000, vx_q});
   assign ny = $signed({2'b00, y_q}) + $signed({{4{vy_q[7]}}, vy_q});

   assign make_hit      = (y_q < C_RIM_Y10) && (ny >= C_RIM_Y12) &&
                          (nx >= C_RIM_XL) && (nx <= C_RIM_XR);
   assign miss_hit      = (nx > C_XMAX12) || (ny >= C_FLOOR12);
   assign y_top_clamped = ny[11] ? 10'd0 : ny[9:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= C_START_X;
         y_q         <= C_START_Y;
         vx_q        <= '0;
         vy_q        <= '0;
         grav_q      <= '0;
         hold_q      <= '0;
         in_flight_q <= 1'b0;
         scored_q    <= 1'b0;
         missed_q    <= 1'b0;
         shots_q     <= '0;
         makes_q     <= '0;
      end else begin
         scored_q <= 1'b0;
         missed_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  vx_q        <= vx_init;
                  vy_q        <= vy_init;
                  grav_q      <= '0;
                  in_flight_q <= 1'b1;
                  state_q     <= FLIGHT;
                  if (shots_q != 8'hFF) shots_q <= shots_q + 8'd1;
               end
            end
            FLIGHT: begin
               if (frame_tick) begin
                  if (grav_q == C_GRAV_END) begin
                     grav_q <= '0;
                     if (vy_q != 8'sd127) vy_q <= vy_q + 8'sd1;
                  end else begin
                     grav_q <= grav_q + 4'd1;
                  end
                  // A make wins over a simultaneous miss and keeps the raw position.
                  if (make_hit) begin
                     x_q         <= nx[9:0];
                     y_q         <= ny[9:0];
                     scored_q    <= 1'b1;
                     in_flight_q <= 1'b0;
                     hold_q      <= '0;
                     state_q     <= HOLD;
                     if (makes_q != 8'hFF) makes_q <= makes_q + 8'd1;
                  end else if (miss_hit) begin
                     x_q         <= (nx > C_XMAX12) ? C_XMAX10 : nx[9:0];
                     y_q         <= (ny >= C_FLOOR12) ? C_FLOOR10 : y_top_clamped;
                     missed_q    <= 1'b1;
                     in_flight_q <= 1'b0;
                     hold_q      <= '0;
                     state_q     <= HOLD;
                  end else begin
                     x_q <= nx[9:0];
                     y_q <= y_top_clamped;
                  end
               end
            end
            HOLD: begin
               if (frame_tick) begin
                  if (hold_q == C_HOLD_END) begin
                     x_q     <= C_START_X;
                     y_q     <= C_START_Y;
                     state_q <= IDLE;
                  end else begin
                     hold_q <= hold_q + HCW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ball_x    = x_q;
   assign ball_y    = y_q;
   assign in_flight = in_flight_q;
   assign scored    = scored_q;
   assign missed    = missed_q;
   assign shots     = shots_q;
   assign makes     = makes_q;

endmodule
`default_nettype wire

// File: doc/ball_motion.md
# ball_motion

Per-frame ball trajectory engine that sits directly upstream of the pixel generator and drives its `ball_x`/`ball_y` inputs. On a `launch` pulse it latches initial velocities and advances the ball once per `frame_tick` under integer gravity. It detects a make (a downward crossing of the rim plane inside the rim span) or a miss (the floor or the right screen edge). After the outcome it holds the final position for a fixed number of frames, then re-racks the ball. It also keeps shot and make counters for the score display.

## Interface
Parameters:
- `START_X`, 40: rest x position after reset and re-rack (pixels).
- `START_Y`, 400: rest y position after reset and re-rack (pixels).
- `RIM_X_MIN`, 600: left edge of the rim span, inclusive.
- `RIM_X_MAX`, 630: right edge of the rim span, inclusive.
- `RIM_Y`, 256: y coordinate of the rim plane.
- `FLOOR_Y`, 470: floor line; reaching it is a miss.
- `X_MAX`, 639: right screen edge.
- `GRAV_DIV`, 2: number of frame ticks per +1 increment of `vy`; range 1..15.
- `HOLD_FRAMES`, 60: number of frames the final position is held after an outcome.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame, driven from the sync generator at the start of vertical blank.
- `launch`  in  1  one-cycle shot request, debounced upstream.
- `vx_init`  in  6  unsigned horizontal speed in pixels/frame; positive is rightward.
- `vy_init`  in  8  signed two's-complement vertical speed; negative is upward.
- `ball_x`  out  10  ball centre x, feeds the pixel generator.
- `ball_y`  out  10  ball centre y, feeds the pixel generator.
- `in_flight`  out  1  high while in FLIGHT.
- `scored`  out  1  one-cycle pulse on a make.
- `missed`  out  1  one-cycle pulse on a miss.
- `shots`  out  8  number of launches, saturates at 255.
- `makes`  out  8  number of makes, saturates at 255.

## Operation
- States:
  - IDLE: ball at rest position; the only state that accepts `launch`.
  - FLIGHT: ball advances on each `frame_tick`.
  - HOLD: final position frozen; counts frames until re-rack.
- Reset (asynchronous, any state):
  - state = IDLE.
  - `ball_x` = START_X, `ball_y` = START_Y.
  - `in_flight` = 0, `scored` = 0, `missed` = 0.
  - `shots` = 0, `makes` = 0.
  - vx, vy, gravity counter and hold counter = 0.
- IDLE with `launch` = 1:
  - vx ← `vx_init`, vy ← `vy_init`.
  - Gravity counter ← 0.
  - `shots` increments (saturating).
  - State → FLIGHT.
- `launch` in FLIGHT or HOLD is ignored.
- FLIGHT, on each `frame_tick`:
  - Compute in 12-bit signed arithmetic: nx = x + vx and ny = y + vy, using the pre-tick vy.
  - If ny < 0, y is clamped to 0 and the ball stays in FLIGHT.
  - Gravity counter increments. When it reaches GRAV_DIV it clears and vy ← vy + 1; vy saturates at +127.
  - Make: y < RIM_Y, ny ≥ RIM_Y, and RIM_X_MIN ≤ nx ≤ RIM_X_MAX. Result: `scored` pulses, `makes` increments (saturating), state → HOLD.
  - Miss: nx > X_MAX or ny ≥ FLOOR_Y. Result: `missed` pulses, x clamped to X_MAX and/or y clamped to FLOOR_Y, state → HOLD.
  - Make takes priority when make and miss conditions hit on the same tick.
  - Position on a make tick: the computed nx/ny, not clamped.
- HOLD:
  - Hold counter resets on entry and counts `frame_tick`s.
  - At the HOLD_FRAMES-th tick: position ← (START_X, START_Y), state → IDLE.

## Timing
- All outputs are registered.
- Launch: the state change appears the cycle after `launch`. The first motion occurs on the next `frame_tick`, not on the launch cycle.
- `launch` and `frame_tick` in the same IDLE cycle: enter FLIGHT only; no motion on that tick.
- Position update: visible the cycle after `frame_tick`, which is inside vertical blank, so there is no mid-frame tearing.
- `scored`/`missed`: asserted the cycle after the deciding `frame_tick`, for exactly one cycle, in the same cycle as the final position.
- `in_flight`: high from the cycle after the launch through the deciding tick; low in the same cycle `scored`/`missed` pulses.
- Back-to-back `frame_tick` on consecutive cycles: each one is processed.
- `frame_tick` absent: the state is frozen indefinitely.
- Reset asserted mid-FLIGHT or mid-HOLD: outputs return to reset values immediately; no pulse is emitted.

## Test plan
- Reset and launch: default parameters, `vx_init`=10, `vy_init`=−20 (8'hEC), GRAV_DIV=1. Expected: after reset, (40,400) and `shots`=0. After the launch, `in_flight`=1 and `shots`=1. After tick 1: (50,380), vy=−19. After tick 2: (60,361).
- Make: START_X=605, START_Y=200, GRAV_DIV=1, vx=0, vy=0. y sequence: 200, 201, 203, 206, …, 245, 255, 266. Expected: `scored` pulse after tick 12 with (605,266), `makes`=1, `in_flight`=0.
- Right-edge miss: default parameters, GRAV_DIV=1, vx=63, vy=0. After tick 9: (607,436) with no score, because the ball never crosses the rim plane downward from above. After tick 10: `missed` pulse, `ball_x`=639, `ball_y`=445.
- Hold and re-rack: after any outcome, run HOLD_FRAMES=60 ticks. Expected: position frozen through tick 59; (40,400) and IDLE after tick 60. A `launch` during HOLD leaves `shots` unchanged.
- Same-cycle events: `launch` together with `frame_tick` in IDLE. Expected: FLIGHT entered with the position unchanged. A second `launch` mid-flight is ignored.
- Asynchronous reset: assert `rst_n`=0 between clock edges mid-FLIGHT. Expected: (40,400), `in_flight`=0, and the counters cleared before the next edge.
